// File: rtl/rfg_axis_protocol_decoder.sv
// Register-access frame decoder: FIFO bytes -> rfg write/read strobes (1 edge after the byte), reads return on AXIS
// after READ_LATENCY edges; stalls on fifo_empty, holds tdata/tvalid/tlast until m_axis_tready.
module rfg_axis_protocol_decoder #(
  parameter int AWIDTH       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resn,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [7:0]        fifo_read_value,
  output logic [AWIDTH-1:0] rfg_address,
  output logic              rfg_write,
  output logic [7:0]        rfg_write_value,
  output logic              rfg_read,
  input  logic [7:0]        rfg_read_value,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_HEADER,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_RREQ,
    S_RWAIT,
    S_RSEND
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic              incr_q, incr_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [2:0]        lat_q, lat_d;
  logic [AWIDTH-1:0] rfg_address_q, rfg_address_d;
  logic              rfg_write_q, rfg_write_d;
  logic [7:0]        rfg_write_value_q, rfg_write_value_d;
  logic              rfg_read_q, rfg_read_d;
  logic [7:0]        tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;

  logic consume_state;
  logic pop;

  // Only the four byte-consuming states may pop, and never while held in reset.
  assign consume_state = (state_q == S_HEADER) || (state_q == S_ADDR) ||
                         (state_q == S_LEN)    || (state_q == S_WDATA);
  assign pop           = resn && consume_state && !fifo_empty;

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    incr_d            = incr_q;
    addr_d            = addr_q;
    cnt_d             = cnt_q;
    lat_d             = lat_q;
    rfg_address_d     = rfg_address_q;
    rfg_write_d       = 1'b0;
    rfg_write_value_d = rfg_write_value_q;
    rfg_read_d        = 1'b0;
    tdata_d           = tdata_q;
    tvalid_d          = tvalid_q;
    tlast_d           = tlast_q;

    case (state_q)
      S_HEADER: begin
        if (pop) begin
          op_d    = fifo_read_value[7];
          incr_d  = fifo_read_value[6];
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (pop) begin
          addr_d  = fifo_read_value[AWIDTH-1:0];
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (pop) begin
          cnt_d   = {1'b0, fifo_read_value} + 9'd1;
          state_d = op_q ? S_RREQ : S_WDATA;
        end
      end
      S_WDATA: begin
        if (pop) begin
          rfg_write_d       = 1'b1;
          rfg_address_d     = addr_q;
          rfg_write_value_d = fifo_read_value;
          addr_d            = addr_q + AWIDTH'(incr_q);
          cnt_d             = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_HEADER;
          end
        end
      end
      S_RREQ: begin
        rfg_read_d    = 1'b1;
        rfg_address_d = addr_q;
        lat_d         = 3'd0;
        state_d       = S_RWAIT;
      end
      S_RWAIT: begin
        // lat_q counts edges since the strobe edge; capture on the READ_LATENCY-th.
        if (lat_q == LAT_LAST) begin
          tdata_d  = rfg_read_value;
          tvalid_d = 1'b1;
          tlast_d  = (cnt_q == 9'd1);
          state_d  = S_RSEND;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_RSEND: begin
        if (tvalid_q && m_axis_tready) begin
          tvalid_d = 1'b0;
          addr_d   = addr_q + AWIDTH'(incr_q);
          cnt_d    = cnt_q - 9'd1;
          state_d  = (cnt_q == 9'd1) ? S_HEADER : S_RREQ;
        end
      end
      default: begin
        state_d = S_HEADER;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resn) begin
      state_q           <= S_HEADER;
      op_q              <= 1'b0;
      incr_q            <= 1'b0;
      addr_q            <= '0;
      cnt_q             <= 9'd0;
      lat_q             <= 3'd0;
      rfg_address_q     <= '0;
      rfg_write_q       <= 1'b0;
      rfg_write_value_q <= 8'd0;
      rfg_read_q        <= 1'b0;
      tdata_q           <= 8'd0;
      tvalid_q          <= 1'b0;
      tlast_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      op_q              <= op_d;
      incr_q            <= incr_d;
      addr_q            <= addr_d;
      cnt_q             <= cnt_d;
      lat_q             <= lat_d;
      rfg_address_q     <= rfg_address_d;
      rfg_write_q       <= rfg_write_d;
      rfg_write_value_q <= rfg_write_value_d;
      rfg_read_q        <= rfg_read_d;
      tdata_q           <= tdata_d;
      tvalid_q          <= tvalid_d;
      tlast_q           <= tlast_d;
    end
  end

  assign fifo_read       = pop;
  assign rfg_address     = rfg_address_q;
  assign rfg_write       = rfg_write_q;
  assign rfg_write_value = rfg_write_value_q;
  assign rfg_read        = rfg_read_q;
  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign busy            = (state_q != S_HEADER);

endmodule

// File: tb/tb_rfg_axis_protocol_decoder.sv
// Scoreboard bench: frames are expanded into expected strobes/stream bytes at issue time; a monitor checks them.
module tb_rfg_axis_protocol_decoder;
  localparam int AWIDTH = 8;
  localparam int RL     = 2;

  logic              clk = 1'b0;
  logic              resn = 1'b0;
  logic              fifo_empty = 1'b1;
  logic              fifo_read;
  logic [7:0]        fifo_read_value = 8'd0;
  logic [AWIDTH-1:0] rfg_address;
  logic              rfg_write;
  logic [7:0]        rfg_write_value;
  logic              rfg_read;
  logic [7:0]        rfg_read_value;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;
  logic              busy;

  rfg_axis_protocol_decoder #(.AWIDTH(AWIDTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .resn(resn),
    .fifo_empty(fifo_empty), .fifo_read(fifo_read), .fifo_read_value(fifo_read_value),
    .rfg_address(rfg_address), .rfg_write(rfg_write), .rfg_write_value(rfg_write_value),
    .rfg_read(rfg_read), .rfg_read_value(rfg_read_value),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  byte_q[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [8:0]  exp_ax[$];
  logic [7:0]  pay[$];
  logic [7:0]  mmem[256];

  bit mon_en    = 0;
  bit rand_gap  = 0;
  bit rdy_rand  = 0;
  bit rdy_force0 = 0;
  int pops      = 0;
  int gap_at    = -1;
  int gap_len   = 0;

  function automatic logic [7:0] seed(input int i);
    return 8'(i * 37 + 11);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file with READ_LATENCY=2: data is only valid on the cycle the decoder must sample it.
  logic       rf_init = 1'b1;
  logic [7:0] regs[256];
  logic       rv_vld = 1'b0;
  logic [7:0] rv_dat = 8'd0;
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 256; i++) regs[i] <= seed(i);
      rv_vld <= 1'b0;
    end else begin
      if (rfg_write) regs[rfg_address] <= rfg_write_value;
      rv_vld <= rfg_read;
      rv_dat <= regs[rfg_address];
    end
  end
  assign rfg_read_value = rv_vld ? rv_dat : 8'hE7;

  // Reference model: expands a frame into the strobes and stream bytes it must produce.
  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] addr, input logic [7:0] len);
    logic [7:0] a;
    int n;
    a = addr;
    n = int'(len) + 1;
    byte_q.push_back(hdr);
    byte_q.push_back(addr);
    byte_q.push_back(len);
    for (int k = 0; k < n; k++) begin
      if (!hdr[7]) begin
        byte_q.push_back(pay[k]);
        exp_wr.push_back({a, pay[k]});
        mmem[a] = pay[k];
      end else begin
        exp_rd.push_back(a);
        exp_ax.push_back({(k == n - 1), mmem[a]});
      end
      if (hdr[6]) a = a + 8'd1;
    end
  endtask

  task automatic fill_pay(input int n);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(byte_q.size() == 0 && !busy && exp_wr.size() == 0 && exp_rd.size() == 0 &&
             exp_ax.size() == 0 && !m_axis_tvalid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // FIFO front end: first-word-fall-through head of byte_q.
  initial begin : fifo_drv
    bit popped;
    int stall;
    popped = 0;
    stall  = 0;
    forever begin
      @(negedge clk);
      if (popped) begin
        void'(byte_q.pop_front());
        pops++;
      end
      if (pops == gap_at && stall < gap_len) begin
        fifo_empty = 1'b1;
        stall++;
      end else begin
        if (pops != gap_at) stall = 0;
        fifo_empty = (byte_q.size() == 0) || (rand_gap && $urandom_range(0, 3) == 0);
      end
      fifo_read_value = fifo_empty ? 8'($urandom) : byte_q[0];
      #2;
      popped = fifo_read && !fifo_empty;
      if (mon_en && fifo_empty) check("fifo_read_when_empty", 32'(fifo_read), 32'd0);
    end
  end

  initial begin : rdy_drv
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rdy_force0 ? 1'b0 : (rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  initial begin : monitor
    bit         pv;
    logic [8:0] pd;
    logic [15:0] ew;
    logic [7:0]  er;
    logic [8:0]  ea;
    pv = 0;
    pd = 9'd0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rfg_write && rfg_read) check("write_read_exclusive", 32'd1, 32'd0);
        if (rfg_write) begin
          if (exp_wr.size() == 0) check("unexpected_write", 32'(rfg_address), 32'hFFFF);
          else begin
            ew = exp_wr.pop_front();
            check("wr_addr", 32'(rfg_address), 32'(ew[15:8]));
            check("wr_data", 32'(rfg_write_value), 32'(ew[7:0]));
          end
        end
        if (rfg_read) begin
          if (exp_rd.size() == 0) check("unexpected_read", 32'(rfg_address), 32'hFFFF);
          else begin
            er = exp_rd.pop_front();
            check("rd_addr", 32'(rfg_address), 32'(er));
          end
        end
        if (pv) begin
          check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
          check("hold_tdata_tlast", 32'({m_axis_tlast, m_axis_tdata}), 32'(pd));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_ax.size() == 0) check("unexpected_axis", 32'(m_axis_tdata), 32'hFFFF);
          else begin
            ea = exp_ax.pop_front();
            check("axis_tdata", 32'(m_axis_tdata), 32'(ea[7:0]));
            check("axis_tlast", 32'(m_axis_tlast), 32'(ea[8]));
          end
        end
        pv = m_axis_tvalid && !m_axis_tready;
        pd = {m_axis_tlast, m_axis_tdata};
      end else begin
        pv = 0;
      end
    end
  end

  initial begin : main
    int p0;
    int n;
    logic [7:0] hdr;
    for (int i = 0; i < 256; i++) mmem[i] = seed(i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rfg_address", 32'(rfg_address), 32'd0);
    check("rst_rfg_write", 32'(rfg_write), 32'd0);
    check("rst_rfg_write_value", 32'(rfg_write_value), 32'd0);
    check("rst_rfg_read", 32'(rfg_read), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_read", 32'(fifo_read), 32'd0);
    rf_init = 1'b0;
    resn    = 1'b1;
    mon_en  = 1;

    // Continuous write frame with increment
    p0 = pops;
    pay = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(8'h40, 8'h10, 8'h02);
    wait_idle(200);
    check("wr_frame_pop_count", 32'(pops - p0), 32'd6);
    check("wr_frame_busy_low", 32'(busy), 32'd0);

    // Non-incrementing read of a known register
    pay = '{8'h5A};
    send_frame(8'h00, 8'h05, 8'h00);
    send_frame(8'h80, 8'h05, 8'h01);
    wait_idle(200);

    // Backpressure: 10 cycles of tready low with the byte held
    rdy_force0 = 1;
    send_frame(8'hC0, 8'h20, 8'h00);
    n = 0;
    while (!m_axis_tvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_tvalid_seen", 32'(m_axis_tvalid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    end
    rdy_force0 = 0;
    wait_idle(200);
    check("bp_tvalid_dropped", 32'(m_axis_tvalid), 32'd0);
    check("bp_back_to_header", 32'(busy), 32'd0);

    // FIFO starvation for 5 cycles after the first data byte
    gap_at  = pops + 4;
    gap_len = 5;
    pay = '{8'h31, 8'h32, 8'h33};
    send_frame(8'h40, 8'h50, 8'h02);
    wait_idle(200);
    gap_at = -1;

    // Address wrap at 2^AWIDTH-1
    pay = '{8'h11, 8'h22};
    send_frame(8'h40, 8'hFF, 8'h01);
    wait_idle(200);

    // Reset after the ADDR byte of an abandoned frame
    p0 = pops;
    byte_q.push_back(8'h40);
    byte_q.push_back(8'h33);
    n = 0;
    while (pops < p0 + 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abandon_bytes_popped", 32'(pops - p0), 32'd2);
    @(negedge clk);
    resn = 1'b0;
    pay = '{8'h77};
    send_frame(8'h40, 8'h03, 8'h00);
    repeat (4) begin
      @(negedge clk);
      #3;
      check("rst_mid_fifo_read", 32'(fifo_read), 32'd0);
      check("rst_mid_no_write", 32'(rfg_write), 32'd0);
    end
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resn = 1'b1;
    wait_idle(200);

    // Randomized frames with FIFO gaps and random ready
    rand_gap = 1;
    rdy_rand = 1;
    for (int f = 0; f < 40; f++) begin
      hdr = 8'($urandom);
      if (f == 10) begin
        hdr[7] = 1'b0;
        fill_pay(256);
        send_frame(hdr, 8'($urandom), 8'hFF);
      end else if (f == 20) begin
        hdr[7] = 1'b1;
        send_frame(hdr, 8'($urandom), 8'd20);
      end else begin
        n = $urandom_range(0, 6);
        fill_pay(n + 1);
        send_frame(hdr, 8'($urandom), 8'(n));
      end
    end
    wait_idle(20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rfg_axis_protocol_decoder.md
Name: rfg_axis_protocol_decoder

Overview:
- Command decoder sitting directly downstream of the RFG AXIS ingress byte FIFO.
- Pops bytes from the FIFO's first-word-fall-through read port and parses register-access frames.
- Issues single-cycle write/read strobes to the register file.
- Returns read data as a byte AXI-Stream master, with tlast on the final byte of each read frame.

Parameters:
- AWIDTH, 8, register address width in bits (1..8); the address byte is truncated to AWIDTH LSBs.
- READ_LATENCY, 1, clock edges from the edge at which rfg_read is registered high to the edge at which rfg_read_value is sampled (1..4).

Ports:
- clk  in  1  clock
- resn  in  1  reset, synchronous active-low
- fifo_empty  in  1  upstream FIFO empty flag
- fifo_read  out  1  pop strobe, combinational: (state consumes a byte) && !fifo_empty
- fifo_read_value  in  8  FIFO head byte, valid while !fifo_empty
- rfg_address  out  AWIDTH  register address, registered
- rfg_write  out  1  one-cycle write strobe, registered
- rfg_write_value  out  8  write data, registered
- rfg_read  out  1  one-cycle read strobe, registered
- rfg_read_value  in  8  register file read data
- m_axis_tdata  out  8  read-back byte
- m_axis_tvalid  out  1  read-back valid
- m_axis_tlast  out  1  last byte of read frame
- m_axis_tready  in  1  downstream ready
- busy  out  1  high whenever state != HEADER

Behaviour:
- Frame format:
  - HEADER byte: bit7 is op (0 = write, 1 = read); bit6 is incr (1 = address increments after each data byte, wrapping mod 2^AWIDTH); bits 5:0 are ignored.
  - ADDR byte.
  - LEN byte: N = LEN + 1 data bytes (1..256).
  - A write frame is followed by N data bytes; a read frame has no further bytes.
- Reset (resn = 0 at a clock edge):
  - State goes to HEADER.
  - All registered outputs go to 0: rfg_address, rfg_write, rfg_write_value, rfg_read, m_axis_tdata, m_axis_tvalid, m_axis_tlast.
  - Byte counter and latency counter clear.
  - fifo_read = 0 while in reset.
  - Reset mid-frame abandons the frame; the next byte popped is treated as a HEADER.
- A byte is consumed only in HEADER, ADDR, LEN and WDATA, on a cycle with !fifo_empty, and always with fifo_read = 1 in that same cycle. No byte is consumed in any other state.
- HEADER -> ADDR on consume; op and incr are latched.
- ADDR -> LEN on consume; the address is latched.
- LEN -> WDATA (write) or RREQ (read) on consume; remaining count = LEN + 1.
- WDATA, per consumed byte:
  - Next edge: rfg_write = 1, rfg_address = current address, rfg_write_value = byte.
  - Address += incr.
  - Count decrements; when the count reaches 0, go to HEADER.
  - Back-to-back bytes give back-to-back strobes.
  - FIFO empty mid-frame stalls the block with no strobe.
- RREQ:
  - Next edge: rfg_read = 1 (one cycle), rfg_address = current address; go to RWAIT.
- RWAIT:
  - Wait READ_LATENCY edges after the edge that set rfg_read.
  - On that edge: m_axis_tdata = rfg_read_value, m_axis_tvalid = 1, m_axis_tlast = (count == 1); go to RSEND.
- RSEND:
  - tdata, tvalid and tlast are held stable until m_axis_tvalid && m_axis_tready at an edge.
  - On that edge tvalid drops to 0 and the address increments by incr.
  - Count decrements; go to RREQ if the count is nonzero, else to HEADER.
  - No bubble-free streaming is required; minimum cost is 2 + READ_LATENCY cycles per read byte.
- rfg_write and rfg_read are never high in the same cycle; each is high for at most one cycle per data byte.
- Address wrap: with incr = 1 and address 2^AWIDTH - 1, the next address is 0.
- LEN = 0xFF gives 256 transfers, so the count register is 9 bits wide.

Test Plan:
- Write frame: bytes 0x40, 0x10, 0x02, 0xAA, 0xBB, 0xCC pushed continuously -> rfg_write pulses on 3 consecutive cycles with (0x10, 0xAA), (0x11, 0xBB), (0x12, 0xCC); busy then low; fifo_read asserted exactly 6 times.
- Read frame, no incr: bytes 0x80, 0x05, 0x01, register model returning 0x5A at address 0x05, tready = 1 -> two rfg_read pulses at address 0x05; stream 0x5A, 0x5A with tlast only on the second byte.
- Backpressure: read frame 0xC0, 0x20, 0x00 with tready = 0 for 10 cycles -> tvalid = 1 and tdata/tlast stable for all 10 cycles; one handshake occurs, then tvalid = 0 and state returns to HEADER.
- FIFO starvation: write frame with a 5-cycle empty gap between data bytes -> no rfg_write and fifo_read = 0 during the gap; the strobe resumes with the correct address.
- Wrap / AWIDTH = 4: write 0x40, 0x0F, 0x01, 0x11, 0x22 -> writes at addresses 0xF then 0x0.
- Reset mid-frame: resn low after the ADDR byte is consumed, then frame 0x40, 0x03, 0x00, 0x77 -> no strobes before reset is released; afterwards a single rfg_write to address 0x03 with data 0x77.
